fd8_arb: RTL and testbench



---
 rtl/fd8_arb.sv | 134 +++++++++++++
 tb/tb_fd8_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fd8_arb.sv
// Round-robin write arbiter: N requesters share one W-bit register O, one grant at a time.
// Optional burst lock is compiled in with `define FD8_ARB_LOCK_EN (adds the LOCK port).
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for any REQ; arbitrates from PTR on each edge
//   GRANT | GNT[g] high; write D[g] into O if REQ[g] is still held
//   DONE  | ACK[g] high for one cycle; pointer advances (or lock re-grant)

module fd8_arb #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           CK,
    input  logic           RST_N,
    input  logic [N-1:0]   REQ,
    input  logic [N*W-1:0] D,
`ifdef FD8_ARB_LOCK_EN
    input  logic [N-1:0]   LOCK,
`endif
    output logic [N-1:0]   GNT,
    output logic [N-1:0]   ACK,
    output logic [W-1:0]   O,
    output logic           BUSY
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   g;
    logic [PW-1:0]   g_next;
    logic [PW-1:0]   sel_idx;
    logic            sel_valid;
    logic [N-1:0]    sel_oh;
    logic [N-1:0]    g_oh;
    logic [W-1:0]    d_arr [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign d_arr[i] = D[i*W +: W];
    end

    // Scan from ptr upward; iterating backwards lets the nearest candidate win.
    always_comb begin
        int            idx;
        logic [PW-1:0] cand;
        idx       = 0;
        cand      = '0;
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = PW'(idx);
            if (REQ[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Explicit wrap so non-power-of-two N never relies on truncation.
    assign g_next = (g == PW'(N - 1)) ? '0 : g + 1'b1;
    assign sel_oh = N'(1) << sel_idx;
    assign g_oh   = N'(1) << g;

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            ptr   <= '0;
            g     <= '0;
            GNT   <= '0;
            ACK   <= '0;
            O     <= '0;
            BUSY  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        g     <= sel_idx;
                        GNT   <= sel_oh;
                        state <= GRANT;
                        BUSY  <= 1'b1;
                    end
                end
                GRANT: begin
                    GNT <= '0;
                    if (REQ[g]) begin
                        O     <= d_arr[g];
                        ACK   <= g_oh;
                        state <= DONE;
                    end else begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                DONE: begin
                    ACK <= '0;
`ifdef FD8_ARB_LOCK_EN
                    if (LOCK[g] && REQ[g]) begin
                        GNT   <= g_oh;
                        state <= GRANT;
                    end else begin
`else
                    begin
`endif
                        ptr   <= g_next;
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    GNT   <= '0;
                    ACK   <= '0;
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    a_gnt_onehot: assert property (@(posedge CK) disable iff (!RST_N) $onehot0(GNT));
    a_ack_onehot: assert property (@(posedge CK) disable iff (!RST_N) $onehot0(ACK));
    a_busy_state: assert property (@(posedge CK) disable iff (!RST_N) BUSY == (state != IDLE));

endmodule

// File: tb/tb_fd8_arb.sv
// Scoreboard bench for fd8_arb (N=4, W=8); lock burst section runs when FD8_ARB_LOCK_EN is defined.
`timescale 1ns/1ps

module tb_fd8_arb;

    localparam int N = 4;
    localparam int W = 8;

    logic           CK;
    logic           RST_N;
    logic [N-1:0]   REQ;
    logic [N*W-1:0] D;
`ifdef FD8_ARB_LOCK_EN
    logic [N-1:0]   LOCK;
`endif
    logic [N-1:0]   GNT;
    logic [N-1:0]   ACK;
    logic [W-1:0]   O;
    logic           BUSY;

    typedef struct packed {
        logic [N-1:0] ack;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;

    fd8_arb #(.N(N), .W(W)) dut (
        .CK   (CK),
        .RST_N(RST_N),
        .REQ  (REQ),
        .D    (D),
`ifdef FD8_ARB_LOCK_EN
        .LOCK (LOCK),
`endif
        .GNT  (GNT),
        .ACK  (ACK),
        .O    (O),
        .BUSY (BUSY)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_d(input int i, input logic [W-1:0] v);
        D[i*W +: W] = v;
    endtask

    task automatic push_exp(input logic [N-1:0] a, input logic [W-1:0] v);
        exp_t e;
        e.ack  = a;
        e.data = v;
        sb_q.push_back(e);
    endtask

    // Counts negedges until ACK shows up; the count is the gap since the call.
    task automatic wait_ack(input string tag, input int exp_gap);
        int cnt;
        cnt = 0;
        do begin
            @(negedge CK);
            cnt++;
        end while (ACK == '0 && cnt < 12);
        chk(tag, cnt, exp_gap);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        @(negedge CK);
        RST_N = 1'b1;
    endtask

    always @(negedge CK) begin
        if (RST_N === 1'b1 && ACK !== '0) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_ack", 32'(ACK), 32'h0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_ack", 32'(ACK), 32'(mon_e.ack));
                chk("sb_data", 32'(O), 32'(mon_e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0;
        REQ   = '0;
        D     = '0;
`ifdef FD8_ARB_LOCK_EN
        LOCK  = '0;
`endif
        repeat (2) @(negedge CK);
        chk("rst_gnt", 32'(GNT), 32'h0);
        chk("rst_ack", 32'(ACK), 32'h0);
        chk("rst_o", 32'(O), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        RST_N = 1'b1;

        // single requester 2
        @(negedge CK);
        set_d(2, 8'hA5);
        REQ = 4'b0100;
        push_exp(4'b0100, 8'hA5);
        @(negedge CK);
        chk("single_gnt", 32'(GNT), 32'h4);
        chk("single_busy", 32'(BUSY), 32'h1);
        chk("single_ack_early", 32'(ACK), 32'h0);
        @(negedge CK);
        chk("single_o", 32'(O), 32'hA5);
        REQ = '0;
        @(negedge CK);
        chk("single_idle_busy", 32'(BUSY), 32'h0);
        chk("single_idle_ack", 32'(ACK), 32'h0);

        // reset while in GRANT (pointer is 3, so requester 0 is found after wrap)
        set_d(0, 8'h3C);
        REQ = 4'b0001;
        @(negedge CK);
        chk("midrst_pre_gnt", 32'(GNT), 32'h1);
        RST_N = 1'b0;
        #1;
        chk("midrst_gnt", 32'(GNT), 32'h0);
        chk("midrst_ack", 32'(ACK), 32'h0);
        chk("midrst_o", 32'(O), 32'h0);
        chk("midrst_busy", 32'(BUSY), 32'h0);
        @(negedge CK);
        RST_N = 1'b1;
        push_exp(4'b0001, 8'h3C);
        @(negedge CK);
        chk("rel_gnt", 32'(GNT), 32'h1);
        @(negedge CK);
        REQ = '0;
        @(negedge CK);
        chk("rel_idle_busy", 32'(BUSY), 32'h0);

        // round robin with all requesters held, starting from pointer 0
        do_reset();
        for (int i = 0; i < N; i++) set_d(i, 8'(8'h10 + i));
        for (int i = 0; i < 5; i++) push_exp(4'(1 << (i % N)), 8'(8'h10 + (i % N)));
        REQ = 4'b1111;
        wait_ack("rr_gap_first", 2);
        for (int i = 1; i < 5; i++) wait_ack("rr_gap", 3);
        REQ = '0;
        @(negedge CK);
        chk("rr_idle_busy", 32'(BUSY), 32'h0);
        chk("rr_sb_left", 32'(sb_q.size()), 32'h0);

        // withdrawn request, then pointer-unchanged and skip-ahead rounds
        do_reset();
        set_d(1, 8'h77);
        REQ = 4'b0010;
        @(negedge CK);
        chk("wd_gnt", 32'(GNT), 32'h2);
        REQ = '0;
        @(negedge CK);
        chk("wd_ack", 32'(ACK), 32'h0);
        chk("wd_o", 32'(O), 32'h0);
        chk("wd_gnt_clr", 32'(GNT), 32'h0);
        chk("wd_busy", 32'(BUSY), 32'h0);
        set_d(0, 8'h20);
        set_d(1, 8'h21);
        push_exp(4'b0001, 8'h20);
        push_exp(4'b0010, 8'h21);
        push_exp(4'b0001, 8'h20);
        push_exp(4'b0010, 8'h21);
        REQ = 4'b0011;
        wait_ack("wd_gap_first", 2);
        for (int i = 1; i < 4; i++) wait_ack("wd_gap", 3);
        REQ = '0;
        @(negedge CK);
        chk("wd_idle_busy", 32'(BUSY), 32'h0);
        chk("wd_sb_left", 32'(sb_q.size()), 32'h0);

`ifdef FD8_ARB_LOCK_EN
        // locked burst of three writes by requester 0, then rotation to 1
        do_reset();
        set_d(0, 8'h40);
        set_d(1, 8'h41);
        for (int i = 0; i < 3; i++) push_exp(4'b0001, 8'h40);
        push_exp(4'b0010, 8'h41);
        LOCK = 4'b0001;
        REQ  = 4'b0011;
        wait_ack("lock_gap_first", 2);
        wait_ack("lock_gap", 2);
        wait_ack("lock_gap", 2);
        LOCK = '0;
        wait_ack("unlock_gap", 3);
        REQ = '0;
        @(negedge CK);
        chk("lock_idle_busy", 32'(BUSY), 32'h0);
        chk("lock_sb_left", 32'(sb_q.size()), 32'h0);
`endif

        repeat (2) @(negedge CK);
        chk("final_sb_left", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
